fifo_write_packer: RTL and testbench
====================================

// Module: fifo_write_packer
// PURPOSE
//  Write-side front end of a dual-clock FIFO, running entirely in the wrclk domain.
//  - Gathers narrow IN_WIDTH items from an upstream pipeline into PACK-slot words.
//  - Tags each word with a per-slot valid mask and drives the FIFO's writeEnable/dataIn.
//  - Registers the FIFO's octant almostFull as a stop signal to upstream.
//  - Flags upstream pipelines that overrun their allowed stop slack.
// PARAMETERS
//  IN_WIDTH    8   width of one input item
//  PACK        4   items per FIFO word (>=2)
//  STOP_SLACK  4   cycles upstream may keep sending after upstreamStop rises
//  CNT_WIDTH   16  width of the words-written counter
// PORTS
//  wrclk           in   1                     write-domain clock
//  rst             in   1                     synchronous, active-high reset
//  inValid         in   1                     inData carries an item this cycle
//  inData          in   IN_WIDTH              item
//  flush           in   1                     close the current word (partial allowed)
//  fifoAlmostFull  in   1                     almostFull from the FIFO write side
//  upstreamStop    out  1                     registered fifoAlmostFull; upstream must stop
//  writeEnable     out  1                     FIFO write strobe
//  dataIn          out  PACK+IN_WIDTH*PACK    {mask[PACK-1:0], slot[PACK-1]..slot[0]}
//  wordsWritten    out  CNT_WIDTH             count of writeEnable pulses; wraps
//  protocolError   out  1                     sticky: item arrived beyond STOP_SLACK
// BEHAVIOUR
//  Reset values (rst high at an edge)
//   - writeEnable=0, dataIn=0, wordsWritten=0, protocolError=0.
//   - upstreamStop=1 (conservative); accumulator empty, slot index=0, slack counter=0.
//   - rst mid-word discards any partial accumulation; no word is emitted.
//  Accumulation
//   - The item on inValid is stored in slot idx, at bits [idx*IN_WIDTH +: IN_WIDTH].
//   - The same cycle sets mask[idx]; idx then increments.
//   - Slot 0 is the oldest item and sits in the LSBs.
//  Word close
//   - A word closes in cycle N when any of:
//     (a) inValid and idx==PACK-1;
//     (b) flush and (inValid or mask!=0).
//   - On close: writeEnable=1 in cycle N+1 with the full word and mask.
//   - The accumulator clears, and idx=0 for cycle N+1.
//   - An item in N+1 goes straight into slot 0, so there is no bubble.
//   - Sustained input gives one write per PACK items.
//  Flush corner cases
//   - flush with inValid: the item is included, then the word closes.
//   - flush with an empty accumulator and no inValid: no-op, no write.
//   - Unused slots of a partial word are zero; their mask bits are 0.
//  writeEnable
//   - A single-cycle pulse, independent of fifoAlmostFull.
//   - The FIFO's octant margin absorbs writes in flight; this block never drops or holds words.
//  Stop path
//   - upstreamStop <= fifoAlmostFull every cycle: one register, latency 1.
//  Slack counter
//   - Clears when upstreamStop=0.
//   - Increments, saturating at STOP_SLACK+1, for each cycle upstreamStop=1.
//   - inValid while the counter equals STOP_SLACK+1 sets protocolError; only rst clears it.
//   - The offending item is still packed normally.
//  Counter
//   - wordsWritten increments in the same cycle writeEnable is high.
//   - Modulo 2^CNT_WIDTH, no saturation.
// TESTING
//  T1 PACK=4, IN_WIDTH=8, items 0x11,0x22,0x33,0x44 on consecutive cycles:
//     -> one write, 1 cycle after the 0x44 cycle; dataIn={4'hF,32'h44332211}.
//  T2 Items 0xA1,0xA2, flush with the 0xA2 cycle:
//     -> dataIn={4'h3,32'h0000A2A1}; a following flush with no data gives no write.
//  T3 8 back-to-back items 0x01..0x08:
//     -> writes in 2 adjacent-word cycles, 4 apart.
//     -> words 0x04030201 and 0x08070605, both with mask F; wordsWritten=2.
//  T4 fifoAlmostFull rises at cycle 10:
//     -> upstreamStop=1 at cycle 11.
//     -> items through cycle 15 are legal; an item at cycle 16 sets protocolError=1, still packed.
//  T5 rst asserted after 3 items:
//     -> no write; the next 4 items produce mask F holding only the post-reset items.
//     -> upstreamStop=1 during reset.
//  T6 CNT_WIDTH=4, 17 full words:
//     -> wordsWritten wraps to 1.

Source files
------------

// File: rtl/fifo_write_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_packer
// Purpose  : Packs narrow upstream items into masked words for a dual-clock
//            FIFO write port, and polices the upstream stop slack.
// Revision : 1.0  initial release
// ============================================================================
module fifo_write_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int PACK       = 4,
  parameter int STOP_SLACK = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         wrclk,
  input  logic                         rst,
  input  logic                         inValid,
  input  logic [IN_WIDTH-1:0]          inData,
  input  logic                         flush,
  input  logic                         fifoAlmostFull,
  output logic                         upstreamStop,
  output logic                         writeEnable,
  output logic [PACK+IN_WIDTH*PACK-1:0] dataIn,
  output logic [CNT_WIDTH-1:0]         wordsWritten,
  output logic                         protocolError
);

  localparam int IDX_W   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int SLACK_W = $clog2(STOP_SLACK + 2);
  localparam logic [IDX_W-1:0]   c_LAST_IDX  = IDX_W'(PACK - 1);
  localparam logic [SLACK_W-1:0] c_SLACK_MAX = SLACK_W'(STOP_SLACK + 1);

  logic [IN_WIDTH*PACK-1:0]        r_slots;
  logic [PACK-1:0]                 r_mask;
  logic [IDX_W-1:0]                r_idx;
  logic [SLACK_W-1:0]              r_slack;
  logic                            r_stop;
  logic                            r_we;
  logic [PACK+IN_WIDTH*PACK-1:0]   r_dataIn;
  logic [CNT_WIDTH-1:0]            r_words;
  logic                            r_err;

  logic [IN_WIDTH*PACK-1:0]        w_nextSlots;
  logic [PACK-1:0]                 w_nextMask;
  logic                            w_close;

  // Accumulator contents including this cycle's item, so a closing word
  // carries the item that closed it.
  always_comb begin
    w_nextSlots = r_slots;
    w_nextMask  = r_mask;
    for (int i = 0; i < PACK; i++) begin
      if (inValid && (r_idx == IDX_W'(i))) begin
        w_nextSlots[i*IN_WIDTH +: IN_WIDTH] = inData;
        w_nextMask[i]                       = 1'b1;
      end
    end
  end

  assign w_close = (inValid && (r_idx == c_LAST_IDX)) ||
                   (flush && (inValid || (r_mask != '0)));

  always_ff @(posedge wrclk) begin
    if (rst) begin
      r_slots  <= '0;
      r_mask   <= '0;
      r_idx    <= '0;
      r_we     <= 1'b0;
      r_dataIn <= '0;
      r_words  <= '0;
    end else begin
      r_we <= w_close;
      if (w_close) begin
        r_dataIn <= {w_nextMask, w_nextSlots};
        r_words  <= r_words + CNT_WIDTH'(1);
        r_slots  <= '0;
        r_mask   <= '0;
        r_idx    <= '0;
      end else begin
        r_slots <= w_nextSlots;
        r_mask  <= w_nextMask;
        if (inValid) begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  // Stop path and slack policing; stop comes out of reset asserted.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      r_stop  <= 1'b1;
      r_slack <= '0;
      r_err   <= 1'b0;
    end else begin
      r_stop <= fifoAlmostFull;
      if (!r_stop) begin
        r_slack <= '0;
      end else if (r_slack != c_SLACK_MAX) begin
        r_slack <= r_slack + SLACK_W'(1);
      end
      if (inValid && (r_slack == c_SLACK_MAX)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign upstreamStop  = r_stop;
  assign writeEnable   = r_we;
  assign dataIn        = r_dataIn;
  assign wordsWritten  = r_words;
  assign protocolError = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_packer
// Purpose  : Directed self-checking bench for fifo_write_packer.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_write_packer;

  logic        wrclk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [7:0]  inData;
  logic        flush;
  logic        fifoAlmostFull;
  logic        upstreamStop;
  logic        writeEnable;
  logic [35:0] dataIn;
  logic [15:0] wordsWritten;
  logic        protocolError;

  logic        upstreamStop2;
  logic        writeEnable2;
  logic [35:0] dataIn2;
  logic [3:0]  wordsWritten2;
  logic        protocolError2;

  int total = 0;
  int bad   = 0;

  always #5 wrclk = ~wrclk;

  fifo_write_packer dut (
    .wrclk(wrclk), .rst(rst), .inValid(inValid), .inData(inData),
    .flush(flush), .fifoAlmostFull(fifoAlmostFull),
    .upstreamStop(upstreamStop), .writeEnable(writeEnable), .dataIn(dataIn),
    .wordsWritten(wordsWritten), .protocolError(protocolError)
  );

  fifo_write_packer #(.CNT_WIDTH(4)) dut4 (
    .wrclk(wrclk), .rst(rst), .inValid(inValid), .inData(inData),
    .flush(flush), .fifoAlmostFull(fifoAlmostFull),
    .upstreamStop(upstreamStop2), .writeEnable(writeEnable2), .dataIn(dataIn2),
    .wordsWritten(wordsWritten2), .protocolError(protocolError2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Registers then reflect the cycle whose inputs were just driven.
  task automatic tick();
    @(posedge wrclk);
    #1;
  endtask

  task automatic item(input logic [7:0] d);
    inValid = 1'b1;
    inData  = d;
    tick();
    inValid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    inValid = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inData = '0; flush = 1'b0; fifoAlmostFull = 1'b0;
    tick(); tick();
    chk("rst_we",    64'(writeEnable),   64'd0);
    chk("rst_data",  64'(dataIn),        64'd0);
    chk("rst_cnt",   64'(wordsWritten),  64'd0);
    chk("rst_err",   64'(protocolError), 64'd0);
    chk("rst_stop",  64'(upstreamStop),  64'd1);
    rst = 1'b0;
    tick();
    chk("stop_follow", 64'(upstreamStop), 64'd0);

    // T1: four items make one full word
    item(8'h11); item(8'h22); item(8'h33);
    chk("t1_no_early_we", 64'(writeEnable), 64'd0);
    item(8'h44);
    chk("t1_we",   64'(writeEnable), 64'd1);
    chk("t1_data", 64'(dataIn),      64'hF_4433_2211);
    tick();
    chk("t1_pulse", 64'(writeEnable), 64'd0);
    chk("t1_cnt",   64'(wordsWritten), 64'd1);

    // T2: partial word closed by flush alongside the last item
    item(8'hA1);
    flush = 1'b1;
    item(8'hA2);
    chk("t2_we",   64'(writeEnable), 64'd1);
    chk("t2_data", 64'(dataIn),      64'h3_0000_A2A1);
    tick();
    flush = 1'b0;
    chk("t2_empty_flush", 64'(writeEnable), 64'd0);
    chk("t2_cnt",         64'(wordsWritten), 64'd2);

    // T3: eight back-to-back items, no bubble between words
    doReset();
    item(8'h01); item(8'h02); item(8'h03); item(8'h04);
    chk("t3_we1",   64'(writeEnable), 64'd1);
    chk("t3_data1", 64'(dataIn),      64'hF_0403_0201);
    item(8'h05);
    chk("t3_gap", 64'(writeEnable), 64'd0);
    item(8'h06); item(8'h07); item(8'h08);
    chk("t3_we2",   64'(writeEnable), 64'd1);
    chk("t3_data2", 64'(dataIn),      64'hF_0807_0605);
    tick();
    chk("t3_cnt", 64'(wordsWritten), 64'd2);

    // T4: slack policing after almostFull
    doReset();
    tick();
    chk("t4_stop_low", 64'(upstreamStop), 64'd0);
    fifoAlmostFull = 1'b1;
    tick();
    chk("t4_stop_high", 64'(upstreamStop), 64'd1);
    item(8'h01); item(8'h02); item(8'h03); item(8'h04);
    chk("t4_word1", 64'(dataIn), 64'hF_0403_0201);
    item(8'h55);
    chk("t4_err_legal", 64'(protocolError), 64'd0);
    flush = 1'b1;
    item(8'h66);
    chk("t4_err_set", 64'(protocolError), 64'd1);
    chk("t4_packed",  64'(dataIn),        64'h3_0000_6655);
    flush = 1'b0;
    fifoAlmostFull = 1'b0;
    tick(); tick();
    chk("t4_err_sticky", 64'(protocolError), 64'd1);

    // T5: reset mid-word discards the partial accumulation
    doReset();
    chk("t5_err_clr", 64'(protocolError), 64'd0);
    item(8'hB1); item(8'hB2); item(8'hB3);
    rst = 1'b1;
    tick();
    chk("t5_stop_rst", 64'(upstreamStop), 64'd1);
    chk("t5_no_we",    64'(writeEnable),  64'd0);
    rst = 1'b0;
    item(8'hC1); item(8'hC2); item(8'hC3);
    chk("t5_no_early", 64'(writeEnable), 64'd0);
    item(8'hC4);
    chk("t5_we",   64'(writeEnable), 64'd1);
    chk("t5_data", 64'(dataIn),      64'hF_C4C3_C2C1);

    // T6: 17 full words wrap a 4-bit counter to 1
    doReset();
    for (int w = 0; w < 17; w++) begin
      for (int s = 0; s < 4; s++) begin
        item(8'(w * 4 + s));
      end
    end
    tick();
    chk("t6_wrap4",  64'(wordsWritten2), 64'd1);
    chk("t6_cnt16",  64'(wordsWritten),  64'd17);
    chk("t6_last",   64'(dataIn2),       64'hF_4342_4140);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
